// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the command-responder ALU.
//   op_t     : 3-bit operation encodings (110/111 are illegal and have no name)
//   cmd_t    : one command as seen on the cmd interface (op_code, a, b)
//   rslt_t   : one result as seen on the rslt interface (out, carry)
//   state_t  : alu_core control FSM states
//   mul_cycles() : cycles the iterative multiplier needs per product
package alu_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int MUL_STEP_DEF = 1;
  localparam int MUL_CYCLES   = DATA_W_DEF / MUL_STEP_DEF;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  typedef struct packed {
    logic [2:0]            op_code;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] out;
    logic                  carry;
  } rslt_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

  // Number of shift-add iterations for a width/step pair. The step must be
  // 1, 2 or 4 and must divide the width.
  function automatic int mul_cycles(input int width, input int step);
    return width / step;
  endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// alu_seq_mult: iterative unsigned shift-add multiplier.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, abandons any product in flight
//   go      : load a/b and clear the accumulator (one-cycle pulse)
//   a, b    : operands, sampled only on go
//   done    : high during the final iteration cycle; product is valid then
//   product : full 2*DATA_W product (combinational, includes the current step)
// MUL_STEP multiplier bits are consumed per cycle, so a product needs
// DATA_W/MUL_STEP cycles after go.
module alu_seq_mult
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CYCLES = mul_cycles(DATA_W, MUL_STEP);
  localparam int CNT_W  = $clog2(CYCLES + 1);

  logic                  run_q,    run_d;
  logic [2*DATA_W-1:0]   mcand_q,  mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [2*DATA_W-1:0]   step_sum_s;
  logic                  last_s;

  // Accumulator plus this cycle's MUL_STEP partial products.
  always_comb begin
    step_sum_s = acc_q;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) begin
        step_sum_s = step_sum_s + (mcand_q << j);
      end else begin
        step_sum_s = step_sum_s;
      end
    end
  end

  assign last_s = run_q && (cnt_q == CNT_W'(CYCLES - 1));

  // Next-state for operand shifters, accumulator and iteration counter.
  always_comb begin
    run_d    = run_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (go) begin
      run_d    = 1'b1;
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (run_q) begin
      acc_d    = step_sum_s;
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      cnt_d    = cnt_q + CNT_W'(1);
      run_d    = ~last_s;
    end else begin
      run_d    = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      run_q    <= run_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done    = last_s;
  assign product = step_sum_s;

endmodule

// File: rtl/alu_core.sv
// alu_core: command-responder ALU.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset; drops any command or multiply
//   start   : command valid, sampled only while busy=0
//   op_code : operation (see alu_pkg::op_t; 110/111 illegal)
//   a, b    : operands
//   ready   : one-cycle pulse, out/carry valid
//   busy    : high while a multiply is running
//   carry   : carry / borrow / overflow / illegal flag
//   out     : result, held until the next result or reset
// Logic, add and subtract answer one cycle after start. Multiply runs in
// alu_seq_mult and answers DATA_W/MUL_STEP cycles after start.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic              busy,
  output logic              carry,
  output logic [DATA_W-1:0] out
);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     out_q,   out_d;
  logic                  carry_q, carry_d;
  logic                  ready_q, ready_d;
  logic                  busy_q,  busy_d;

  logic                  mul_go_s;
  logic                  mul_done_s;
  logic [2*DATA_W-1:0]   mul_product_s;
  logic [DATA_W:0]       add_s;
  logic [DATA_W:0]       sub_s;

  // Extra top bit: carry-out for add, unsigned borrow (a<b) for subtract.
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};

  alu_seq_mult #(
    .DATA_W   (DATA_W),
    .MUL_STEP (MUL_STEP)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .go      (mul_go_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Control FSM, single-cycle datapath and result selection.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    carry_d  = carry_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    mul_go_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_code)
            OP_NOP: begin
              ready_d = 1'b0;
            end
            OP_ADD: begin
              out_d   = add_s[DATA_W-1:0];
              carry_d = add_s[DATA_W];
              ready_d = 1'b1;
            end
            OP_AND: begin
              out_d   = a & b;
              carry_d = 1'b0;
              ready_d = 1'b1;
            end
            OP_XOR: begin
              out_d   = a ^ b;
              carry_d = 1'b0;
              ready_d = 1'b1;
            end
            OP_SUB: begin
              out_d   = sub_s[DATA_W-1:0];
              carry_d = sub_s[DATA_W];
              ready_d = 1'b1;
            end
            OP_MUL: begin
              mul_go_s = 1'b1;
              busy_d   = 1'b1;
              state_d  = ST_MUL_RUN;
            end
            default: begin
              // Illegal op: answer with an error flag so it is not lost.
              out_d   = '0;
              carry_d = 1'b1;
              ready_d = 1'b1;
            end
          endcase
        end else begin
          ready_d = 1'b0;
        end
      end
      ST_MUL_RUN: begin
        // start is ignored here: no queuing, operands already latched.
        if (mul_done_s) begin
          out_d   = mul_product_s[DATA_W-1:0];
          carry_d = |mul_product_s[2*DATA_W-1:DATA_W];
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign carry = carry_q;
  assign out   = out_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed, table-driven bench for alu_core at the default
// parameters (DATA_W=32, MUL_STEP=1, 32-cycle multiply).
module tb_alu_core;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int MCYC  = 32;
  localparam int NVEC  = 11;

  logic          clk;
  logic          reset;
  logic          start;
  logic [2:0]    op_code;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          busy;
  logic          carry;
  logic [W-1:0]  out;

  int total;
  int bad;

  typedef struct {
    logic  start;
    cmd_t  cmd;
    logic  exp_ready;
    rslt_t exp;
  } vec_t;

  vec_t vecs [NVEC];

  alu_core #(.DATA_W(W), .MUL_STEP(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_code (op_code),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .carry   (carry),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic st, input logic [2:0] op,
                         input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic r, input logic [W-1:0] o, input logic c);
    vecs[i].start     = st;
    vecs[i].cmd.op_code = op;
    vecs[i].cmd.a     = va;
    vecs[i].cmd.b     = vb;
    vecs[i].exp_ready = r;
    vecs[i].exp.out   = o;
    vecs[i].exp.carry = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a MUL, optionally poke an ADD at cycle inj (0 = none), and check
  // busy/ready per cycle and the final result.
  task automatic run_mul(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] exp_o, input logic exp_c, input int inj);
    start = 1'b1; op_code = OP_MUL; a = va; b = vb;
    tick();
    start = 1'b0;
    for (int k = 1; k <= MCYC; k++) begin
      if (k == inj) begin
        start = 1'b1; op_code = OP_ADD; a = 32'h1; b = 32'h1;
      end
      tick();
      start = 1'b0;
      if (k < MCYC) begin
        chk("mul_busy", busy, 1'b1);
        chk("mul_ready_early", ready, 1'b0);
      end else begin
        chk("mul_ready", ready, 1'b1);
        chk("mul_busy_end", busy, 1'b0);
        chk("mul_out", out, exp_o);
        chk("mul_carry", carry, exp_c);
      end
    end
    tick();
    chk("mul_ready_once", ready, 1'b0);
    chk("mul_out_held", out, exp_o);
    chk("mul_busy_after", busy, 1'b0);
  endtask

  initial begin
    logic seen;
    total = 0;
    bad   = 0;
    reset = 1'b1; start = 1'b0; op_code = 3'b000; a = '0; b = '0;

    set_vec(0,  1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1);
    set_vec(1,  1'b0, OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1);
    set_vec(2,  1'b1, OP_XOR, 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b1, 32'hA5A5_5A5A, 1'b0);
    set_vec(3,  1'b1, OP_NOP, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'hA5A5_5A5A, 1'b0);
    set_vec(4,  1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0);
    set_vec(5,  1'b1, OP_SUB, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
    set_vec(6,  1'b1, OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1);
    set_vec(7,  1'b1, 3'b111, 32'h0000_0003, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b1);
    set_vec(8,  1'b1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0);
    set_vec(9,  1'b1, 3'b110, 32'h1234_5678, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1);
    set_vec(10, 1'b1, OP_NOP, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b1);

    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_out",   out,   32'h0);
    chk("rst_carry", carry, 1'b0);

    // Back-to-back single-cycle table.
    for (int i = 0; i < NVEC; i++) begin
      start   = vecs[i].start;
      op_code = vecs[i].cmd.op_code;
      a       = vecs[i].cmd.a;
      b       = vecs[i].cmd.b;
      tick();
      chk($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_out", i),   out,   vecs[i].exp.out);
      chk($sformatf("vec%0d_carry", i), carry, vecs[i].exp.carry);
      chk($sformatf("vec%0d_busy", i),  busy,  1'b0);
    end
    start = 1'b0;
    tick();

    // Two consecutive SUBs give two consecutive ready pulses.
    start = 1'b1; op_code = OP_SUB; a = 32'd5; b = 32'd7;
    tick();
    chk("sub1_ready", ready, 1'b1);
    chk("sub1_out",   out,   32'hFFFF_FFFE);
    chk("sub1_carry", carry, 1'b1);
    a = 32'd7; b = 32'd5;
    tick();
    start = 1'b0;
    chk("sub2_ready", ready, 1'b1);
    chk("sub2_out",   out,   32'h0000_0002);
    chk("sub2_carry", carry, 1'b0);
    tick();
    chk("sub_idle_ready", ready, 1'b0);

    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 0);
    run_mul(32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 0);
    run_mul(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 5);
    // ADD presented on the final multiply edge must be dropped.
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, MCYC);

    // Reset in the middle of a multiply.
    start = 1'b1; op_code = OP_MUL; a = 32'h0000_1234; b = 32'h0000_0010;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy",  busy,  1'b0);
    chk("abort_ready", ready, 1'b0);
    chk("abort_out",   out,   32'h0);
    chk("abort_carry", carry, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("abort_no_ready", seen, 1'b0);
    start = 1'b1; op_code = OP_AND; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
    tick();
    start = 1'b0;
    chk("post_and_ready", ready, 1'b1);
    chk("post_and_out",   out,   32'hF000_F000);
    chk("post_and_carry", carry, 1'b0);

    // Reset and start on the same edge: reset wins.
    reset = 1'b1; start = 1'b1; op_code = OP_ADD; a = 32'hFFFF_FFFF; b = 32'h1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_start_ready", ready, 1'b0);
    chk("rst_start_out",   out,   32'h0);
    chk("rst_start_carry", carry, 1'b0);
    tick();
    chk("rst_start_ready2", ready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Command-responder ALU: the design-under-test end of the cmd/rslt interface driven by the class-based tester and watched by the command/result monitors.
- Accepts one command (a, b, op_code) per start pulse. Returns out, carry and a one-cycle ready pulse.
- Logic ops and add/sub take a single cycle. Multiply is iterative and multi-cycle.

Parameters:
- DATA_W, 32: operand and result width.
- MUL_STEP, 1: multiplier bits consumed per cycle. Legal values are 1, 2 and 4, and the value must divide DATA_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command valid; sampled only when busy=0
- op_code  in  3  operation select
- a  in  DATA_W  operand A
- b  in  DATA_W  operand B
- ready  out  1  one-cycle pulse: out and carry are valid
- busy  out  1  high while a multiply is in progress
- carry  out  1  carry, borrow or overflow flag
- out  out  DATA_W  result

Behaviour:
- Reset (sampled at a clk edge with reset=1): state=IDLE; ready=0, busy=0, carry=0, out=0. Any in-flight multiply is discarded and produces no ready.
- Op codes: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB, 110/111 ILLEGAL.
- FSM states: IDLE, MUL_RUN.
- IDLE, start=0: stay in IDLE; ready=0.
- IDLE, start=1, NOP: no ready, outputs unchanged.
- IDLE, start=1, ADD/AND/XOR/SUB/ILLEGAL: registered result; ready=1 for the cycle after edge N (latency 1). Stay in IDLE, so back-to-back commands every cycle are legal.
- IDLE, start=1, MUL: latch a and b, clear the 2*DATA_W accumulator, go to MUL_RUN; busy=1 from the cycle after edge N.
- MUL_RUN: each edge adds MUL_STEP partial products, shift-add style. After DATA_W/MUL_STEP edges, write the result, drive ready=1 for one cycle, busy=0, and return to IDLE.
- MUL latency: start sampled at edge N gives ready high in the cycle after edge N+DATA_W/MUL_STEP (32 cycles at the defaults).
- start while busy=1: ignored; no queuing; operands are not re-sampled.
- ready is high for exactly one cycle per accepted non-NOP command. out and carry hold their last value until the next result or reset.
- Arithmetic:
  - ADD: out = (a+b) mod 2^DATA_W; carry = bit DATA_W of the sum.
  - SUB: out = (a-b) mod 2^DATA_W; carry = 1 iff a<b (unsigned borrow).
  - AND/XOR: out = a&b or a^b; carry=0.
  - MUL: unsigned 2*DATA_W product; out = low DATA_W bits; carry = OR of the high DATA_W bits.
  - ILLEGAL: out=0, carry=1, ready pulses; this flags the error to the scoreboard.
- reset together with start on the same edge: reset wins; the command is dropped.
- The final MUL edge coincides with a new start: the new start is ignored, because busy=1 at that edge.

Decomposition:
- Shared package alu_pkg:
  - op_t enum (NOP, ADD, AND, XOR, MUL, SUB) with the 3-bit encodings above.
  - cmd and rslt typedefs, reused by the testbench.
  - Constant MUL_CYCLES = DATA_W/MUL_STEP.
- One sub-module, alu_seq_mult: iterative multiplier with ports clk, reset, go, a, b, done, product[2*DATA_W-1:0].
  - alu_core owns the FSM, single-cycle datapath and output registers.
  - alu_seq_mult is cleared by reset and by go.

Test Plan:
- ADD a=0xFFFF_FFFF, b=0x1 -> one cycle later ready=1, out=0x0000_0000, carry=1; next cycle ready=0, out held.
- SUB a=5, b=7 -> out=0xFFFF_FFFE, carry=1. Then SUB a=7, b=5 on the very next cycle -> out=0x2, carry=0. Two consecutive ready pulses.
- MUL a=0x0001_0000, b=0x0001_0000 -> busy=1 for 32 cycles, then ready=1, out=0, carry=1. MUL a=0x1234, b=0x10 -> out=0x12340, carry=0.
- During MUL, pulse start with ADD a=1, b=1 at cycle 5 -> ignored; exactly one ready, carrying the MUL result, at cycle 33.
- Assert reset at cycle 10 of a MUL -> next cycle busy=0, ready=0, out=0, carry=0; no ready ever appears for that MUL. A following AND a=0xF0F0_F0F0, b=0xFF00_FF00 -> out=0xF000_F000.
- NOP with a=3, b=4 -> no ready, out unchanged. op_code=111 -> ready=1, out=0, carry=1.
